// File: rtl/mem_wb_stage.sv
// rtl/mem_wb_stage.sv - MEM/WB pipeline stage with blocking data-memory load and timeout
module mem_wb_stage #(
  parameter int unsigned TIMEOUT_CYCLES = 15
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] alu_in,
  input  logic [4:0]  dst_in,
  input  logic        reg_write_in,
  input  logic        reg_dst_in,
  input  logic        mem_reg_dst_in,
  input  logic [31:0] baddr_in,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        stall,
  output logic [31:0] wb_data,
  output logic [4:0]  wb_dst,
  output logic        wb_write,
  output logic        wb_reg_dst,
  output logic [31:0] wb_baddr,
  output logic        mem_err
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

  // Declaration initialisers give the all-zero power-up state ahead of the first reset.
  state_t      state_q      = IDLE;
  logic [7:0]  cnt_q        = '0;
  logic [31:0] addr_q       = '0;
  logic [4:0]  dst_lat_q    = '0;
  logic        reg_dst_lat_q = 1'b0;
  logic [31:0] baddr_lat_q  = '0;
  logic [31:0] wb_data_q    = '0;
  logic [4:0]  wb_dst_q     = '0;
  logic        wb_write_q   = 1'b0;
  logic        wb_reg_dst_q = 1'b0;
  logic [31:0] wb_baddr_q   = '0;
  logic        mem_err_q    = 1'b0;

  logic load;

  assign load     = reg_write_in & mem_reg_dst_in;
  assign stall    = ((state_q == IDLE) && load) || (state_q == REQ);
  assign mem_req  = (state_q == REQ);
  assign mem_addr = addr_q;

  assign wb_data    = wb_data_q;
  assign wb_dst     = wb_dst_q;
  assign wb_write   = wb_write_q;
  assign wb_reg_dst = wb_reg_dst_q;
  assign wb_baddr   = wb_baddr_q;
  assign mem_err    = mem_err_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      addr_q        <= '0;
      dst_lat_q     <= '0;
      reg_dst_lat_q <= 1'b0;
      baddr_lat_q   <= '0;
      wb_data_q     <= '0;
      wb_dst_q      <= '0;
      wb_write_q    <= 1'b0;
      wb_reg_dst_q  <= 1'b0;
      wb_baddr_q    <= '0;
      mem_err_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (load) begin
            addr_q        <= alu_in;
            dst_lat_q     <= dst_in;
            reg_dst_lat_q <= reg_dst_in;
            baddr_lat_q   <= baddr_in;
            wb_write_q    <= 1'b0;
            cnt_q         <= '0;
            state_q       <= REQ;
          end else begin
            wb_data_q    <= alu_in;
            wb_dst_q     <= dst_in;
            wb_write_q   <= reg_write_in;
            wb_reg_dst_q <= reg_dst_in;
            wb_baddr_q   <= baddr_in;
          end
        end
        REQ: begin
          // An ack arriving on the last permitted cycle still wins over the timeout.
          if (mem_ack) begin
            wb_data_q    <= mem_rdata;
            wb_dst_q     <= dst_lat_q;
            wb_reg_dst_q <= reg_dst_lat_q;
            wb_baddr_q   <= baddr_lat_q;
            wb_write_q   <= 1'b1;
            state_q      <= DONE;
          end else if (cnt_q == CNT_LAST) begin
            mem_err_q  <= 1'b1;
            wb_write_q <= 1'b0;
            state_q    <= DONE;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        DONE: begin
          wb_write_q <= 1'b0;
          state_q    <= IDLE;
        end
        default: begin
          wb_write_q <= 1'b0;
          state_q    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb/tb_mem_wb_stage.sv - scoreboard bench for mem_wb_stage with randomized traffic
module tb_mem_wb_stage;

  localparam int TO = 15;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] alu_in = '0;
  logic [4:0]  dst_in = '0;
  logic        reg_write_in = 1'b0;
  logic        reg_dst_in = 1'b0;
  logic        mem_reg_dst_in = 1'b0;
  logic [31:0] baddr_in = '0;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        stall;
  logic [31:0] wb_data;
  logic [4:0]  wb_dst;
  logic        wb_write;
  logic        wb_reg_dst;
  logic [31:0] wb_baddr;
  logic        mem_err;

  mem_wb_stage #(.TIMEOUT_CYCLES(TO)) dut (
    .clock(clock), .reset(reset), .alu_in(alu_in), .dst_in(dst_in),
    .reg_write_in(reg_write_in), .reg_dst_in(reg_dst_in),
    .mem_reg_dst_in(mem_reg_dst_in), .baddr_in(baddr_in),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .stall(stall), .wb_data(wb_data),
    .wb_dst(wb_dst), .wb_write(wb_write), .wb_reg_dst(wb_reg_dst),
    .wb_baddr(wb_baddr), .mem_err(mem_err)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [31:0] data;
    logic [4:0]  dst;
    logic        rd;
    logic [31:0] baddr;
  } wb_t;

  wb_t  exp_q[$];
  wb_t  mon_e;
  logic exp_err = 1'b0;
  bit   mon_en = 1'b0;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every write the DUT presents must match the oldest expected writeback.
  always @(negedge clock) begin
    if (mon_en) begin
      chk("mem_err", {31'd0, mem_err}, {31'd0, exp_err});
      if (wb_write === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: got dst %0d data %h expected no write at %0t",
                   wb_dst, wb_data, $time);
        end else begin
          mon_e = exp_q.pop_front();
          chk("wb_data", wb_data, mon_e.data);
          chk("wb_dst", {27'd0, wb_dst}, {27'd0, mon_e.dst});
          chk("wb_reg_dst", {31'd0, wb_reg_dst}, {31'd0, mon_e.rd});
          chk("wb_baddr", wb_baddr, mon_e.baddr);
        end
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic issue_alu(input logic [31:0] a, input logic [4:0] d, input logic rw,
                           input logic rd, input logic [31:0] b);
    alu_in = a; dst_in = d; reg_write_in = rw; mem_reg_dst_in = 1'b0;
    reg_dst_in = rd; baddr_in = b;
    mem_ack = 1'($urandom_range(0, 1));
    mem_rdata = $urandom;
    if (rw) exp_q.push_back('{a, d, rd, b});
    @(negedge clock);
    chk("stall_nonload", {31'd0, stall}, 32'd0);
    chk("mem_req_nonload", {31'd0, mem_req}, 32'd0);
    step();
    chk("wb_write_nonload", {31'd0, wb_write}, {31'd0, rw});
  endtask

  // delay = number of REQ cycles without ack before the ack; delay >= TO means never.
  task automatic issue_load(input logic [31:0] a, input logic [4:0] d, input logic rd,
                            input logic [31:0] b, input int delay, input logic [31:0] rdata);
    alu_in = a; dst_in = d; reg_write_in = 1'b1; mem_reg_dst_in = 1'b1;
    reg_dst_in = rd; baddr_in = b;
    mem_ack = 1'($urandom_range(0, 1));
    @(negedge clock);
    chk("stall_load_idle", {31'd0, stall}, 32'd1);
    chk("mem_req_load_idle", {31'd0, mem_req}, 32'd0);
    step();
    chk("wb_write_bubble", {31'd0, wb_write}, 32'd0);
    for (int k = 0; k < TO; k++) begin
      mem_ack = (k == delay);
      mem_rdata = (k == delay) ? rdata : $urandom;
      if (k == delay) exp_q.push_back('{rdata, d, rd, b});
      @(negedge clock);
      chk("mem_req_in_req", {31'd0, mem_req}, 32'd1);
      chk("mem_addr_in_req", mem_addr, a);
      chk("stall_in_req", {31'd0, stall}, 32'd1);
      step();
      if (k == delay) break;
    end
    if (delay >= TO) exp_err = 1'b1;
    reg_write_in = 1'b0; mem_reg_dst_in = 1'b0;
    mem_ack = 1'($urandom_range(0, 1));
    mem_rdata = $urandom;
    @(negedge clock);
    chk("mem_req_done", {31'd0, mem_req}, 32'd0);
    chk("stall_done", {31'd0, stall}, 32'd0);
    chk("mem_addr_held", mem_addr, a);
    chk("wb_write_done", {31'd0, wb_write}, {31'd0, (delay < TO)});
    step();
  endtask

  task automatic reset_mid_load(input logic [31:0] a, input logic [4:0] d);
    alu_in = a; dst_in = d; reg_write_in = 1'b1; mem_reg_dst_in = 1'b1;
    reg_dst_in = 1'b1; baddr_in = $urandom; mem_ack = 1'b0;
    step();
    step();
    step();
    reset = 1'b1; reg_write_in = 1'b0; mem_reg_dst_in = 1'b0;
    step();
    reset = 1'b0;
    exp_err = 1'b0;
    @(negedge clock);
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    chk("rst_wb_dst", {27'd0, wb_dst}, 32'd0);
    chk("rst_wb_write", {31'd0, wb_write}, 32'd0);
    chk("rst_wb_reg_dst", {31'd0, wb_reg_dst}, 32'd0);
    chk("rst_wb_baddr", wb_baddr, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    mem_ack = 1'b1; mem_rdata = $urandom;
    for (int i = 0; i < 4; i++) step();
    mem_ack = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish by 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    #1;
    chk("pwr_wb_data", wb_data, 32'd0);
    chk("pwr_wb_write", {31'd0, wb_write}, 32'd0);
    chk("pwr_wb_dst", {27'd0, wb_dst}, 32'd0);
    chk("pwr_mem_err", {31'd0, mem_err}, 32'd0);
    chk("pwr_mem_addr", mem_addr, 32'd0);
    step(); step(); step();
    reset = 1'b0;
    chk("rst_wb_baddr0", wb_baddr, 32'd0);
    chk("rst_mem_req0", {31'd0, mem_req}, 32'd0);
    mon_en = 1'b1;

    issue_alu(32'h10, 5'd5, 1'b1, 1'b0, 32'h0);
    issue_load(32'h100, 5'd7, 1'b0, 32'h44, 0, 32'hDEADBEEF);
    issue_load(32'h200, 5'd3, 1'b1, 32'h88, 4, $urandom);
    issue_load(32'h300, 5'd12, 1'b0, 32'h9, 2, $urandom);
    issue_alu(32'h55, 5'd9, 1'b1, 1'b0, 32'h0);
    issue_load(32'h400, 5'd1, 1'b0, 32'h1, TO - 1, $urandom);

    for (int n = 0; n < 150; n++) begin
      r = int'($urandom_range(0, 3));
      if (r == 0)
        issue_load($urandom, 5'($urandom), 1'($urandom), $urandom,
                   int'($urandom_range(0, 6)), $urandom);
      else
        issue_alu($urandom, 5'($urandom), (r != 3), 1'($urandom), $urandom);
    end

    issue_load(32'h500, 5'd4, 1'b1, 32'h5, 20, $urandom);
    for (int n = 0; n < 10; n++) begin
      if (n % 3 == 0)
        issue_load($urandom, 5'($urandom), 1'($urandom), $urandom,
                   int'($urandom_range(0, 3)), $urandom);
      else
        issue_alu($urandom, 5'($urandom), 1'b1, 1'($urandom), $urandom);
    end

    reset_mid_load(32'h600, 5'd6);
    issue_alu(32'h77, 5'd2, 1'b1, 1'b1, 32'h3);
    issue_load(32'h700, 5'd8, 1'b0, 32'h7, 1, $urandom);
    step(); step();

    chk("queue_empty", exp_q.size(), 32'd0);
    mon_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
